// File: rtl/spi_cmd_decoder.sv
// Register-command decoder behind the SPI slave shift stage: decodes each
// completed frame, drives the core register bus and preloads the response word.
module spi_cmd_decoder #(
  parameter  int size   = 32,
  parameter  int awidth = 3,
  localparam int dwidth = size - 1 - awidth
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              scs,
  input  logic [size-1:0]   frm_di,
  output logic [size-1:0]   frm_do,
  output logic              wr_en,
  output logic [awidth-1:0] wr_addr,
  output logic [dwidth-1:0] wr_data,
  output logic [awidth-1:0] rd_addr,
  input  logic [dwidth-1:0] rd_data,
  output logic              busy,
  output logic              ovr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    EXEC = 2'd2,
    READ = 2'd3
  } state_t;

  state_t            state_reg,   state_next;
  logic [1:0]        xcs_reg;
  logic [size-1:0]   frm_do_reg,  frm_do_next;
  logic              wr_en_reg,   wr_en_next;
  logic [awidth-1:0] wr_addr_reg, wr_addr_next;
  logic [dwidth-1:0] wr_data_reg, wr_data_next;
  logic [awidth-1:0] rd_addr_reg, rd_addr_next;
  logic              ovr_reg,     ovr_next;

  logic fall_det;
  logic rise_det;
  logic ovr_set;
  logic frm_ones;

  // Same two-flop shift as the slave, so our edge E matches its pdo update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) xcs_reg <= 2'b00;
    else     xcs_reg <= {xcs_reg[0], scs};
  end

  assign fall_det = ~xcs_reg[0] &  xcs_reg[1];
  assign rise_det =  xcs_reg[0] & ~xcs_reg[1];
  assign frm_ones = &frm_di;
  // Any select edge while a command is in flight means the host was too fast.
  assign ovr_set  = (state_reg != IDLE) & (rise_det | fall_det);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      frm_do_reg  <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      rd_addr_reg <= '0;
      ovr_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      frm_do_reg  <= frm_do_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      rd_addr_reg <= rd_addr_next;
      ovr_reg     <= ovr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    frm_do_next  = frm_do_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    rd_addr_next = rd_addr_reg;
    ovr_next     = ovr_reg | ovr_set;
    case (state_reg)
      IDLE: begin
        if (fall_det) state_next = CAPT;
      end
      CAPT: begin
        rd_addr_next = frm_di[size-2 -: awidth];
        wr_addr_next = frm_di[size-2 -: awidth];
        wr_data_next = frm_di[dwidth-1:0];
        // An all-ones word is a stuck-high MOSI line: treat it as a read.
        wr_en_next   = frm_di[size-1] & ~frm_ones;
        state_next   = EXEC;
      end
      EXEC: begin
        state_next = READ;
      end
      READ: begin
        frm_do_next = {ovr_reg, rd_addr_reg, rd_data};
        ovr_next    = ovr_set;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign frm_do  = frm_do_reg;
  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign rd_addr = rd_addr_reg;
  assign ovr     = ovr_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: emulates the slave and register core, predicts
// each response from the frame rules with a simple register-array model.
module tb_spi_cmd_decoder;

  logic        rst;
  logic        clk;
  logic        scs;
  logic [31:0] frm_di;
  logic [31:0] frm_do;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [27:0] wr_data;
  logic [2:0]  rd_addr;
  logic [27:0] rd_data;
  logic        busy;
  logic        ovr;

  logic [27:0] core_regs [8];
  logic [27:0] mregs [8];
  bit          pending;
  int          checks;
  int          errors;

  spi_cmd_decoder dut (
    .rst     (rst),
    .clk     (clk),
    .scs     (scs),
    .frm_di  (frm_di),
    .frm_do  (frm_do),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .ovr     (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register core stand-in: combinational read, write on the clock edge.
  assign rd_data = core_regs[rd_addr];
  always @(posedge clk) if (wr_en) core_regs[wr_addr] <= wr_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One frame ending at the next negedge; the host re-raises scs after k
  // clocks, so its rise detect lands k edges after the fall-detect edge.
  task automatic do_frame(input logic [31:0] word, input int k);
    logic        w;
    logic [2:0]  a;
    logic [31:0] exp_resp;
    logic        exp_ovr;
    int          hold;
    w = word[31] & ~(&word);
    a = word[30:28];
    if (w) mregs[a] = word[27:0];
    exp_resp = {pending | (k >= 1 && k <= 2), a, mregs[a]};
    exp_ovr  = (k == 3);
    @(negedge clk);
    scs    = 1'b0;
    frm_di = word;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      case (c)
        1: chk("busy_idle", busy, 0);
        2: begin
          chk("busy_capt", busy, 1);
          chk("wr_en_capt", wr_en, 0);
        end
        3: begin
          chk("busy_exec", busy, 1);
          chk("wr_en_exec", wr_en, w);
          chk("rd_addr", rd_addr, a);
          if (w) begin
            chk("wr_addr", wr_addr, a);
            chk("wr_data", wr_data, word[27:0]);
          end
        end
        4: chk("wr_en_read", wr_en, 0);
        5: begin
          chk("frm_do", frm_do, exp_resp);
          chk("ovr", ovr, exp_ovr);
          chk("busy_done", busy, 0);
        end
        default: chk("wr_en_after", wr_en, 0);
      endcase
      if (c == k) scs = 1'b1;
    end
    pending = exp_ovr;
    $display("frame %h k=%0d resp %h (exp %h) ovr %0b", word, k, frm_do, exp_resp, ovr);
    hold = $urandom_range(2, 4);
    repeat (hold) @(negedge clk);
  endtask

  task automatic do_reset_frame(input logic [31:0] word);
    @(negedge clk);
    scs    = 1'b0;
    frm_di = word;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("rst_frm_do", frm_do, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_wr_en", wr_en, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_no_write", wr_en, 0);
    end
    pending = 1'b0;
    $display("reset frame %h aborted, frm_do %h busy %0b", word, frm_do, busy);
    scs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] word;
    int          r;
    int          k;
    checks  = 0;
    errors  = 0;
    pending = 1'b0;
    for (int i = 0; i < 8; i++) begin
      core_regs[i] = '0;
      mregs[i]     = '0;
    end
    rst    = 1'b1;
    scs    = 1'b0;
    frm_di = '0;
    repeat (3) @(negedge clk);
    chk("reset_frm_do", frm_do, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ovr", ovr, 0);
    rst = 1'b0;
    @(negedge clk);
    scs = 1'b1;
    repeat (3) @(negedge clk);

    do_frame(32'h9000_0123, 6);
    chk("write_echo", frm_do, 32'h1000_0123);
    do_frame(32'hBABC_DEF0, 6);
    do_frame(32'h3000_0000, 6);
    chk("read_only", frm_do, 32'h3ABC_DEF0);
    do_frame(32'hFFFF_FFFF, 6);
    chk("all_ones_rd_addr", rd_addr, 7);

    do_frame(32'hA555_1234, 3);
    do_frame(32'h2000_0000, 6);
    chk("overrun_flag", frm_do[31], 1);
    chk("overrun_cleared", ovr, 0);

    do_frame(32'hC000_0077, 3);
    do_reset_frame(32'hC123_4567);
    do_frame(32'h4000_0000, 6);

    do_frame(32'h8000_0011, 4);
    do_frame(32'h9000_0022, 4);
    do_frame(32'hA000_0033, 4);
    chk("b2b_ovr", ovr, 0);

    for (int n = 0; n < 40; n++) begin
      word = $urandom;
      if ($urandom_range(0, 9) == 0) word = 32'hFFFF_FFFF;
      r = $urandom_range(0, 9);
      k = (r < 4) ? r + 1 : 6;
      do_frame(word, k);
    end
    do_frame(32'h0000_0000, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
